// File: rtl/uart_word_tx.sv
// uart_word_tx: shifts a 32-bit word out as NBYTES 8N1 frames, LSB byte first.
// Ports: clock, reset (async high), send/data in; tx, busy, done out (registered).
module uart_word_tx #(
  parameter int CLKS_PER_BIT = 434,
  parameter int NBYTES       = 4
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        send,
  input  logic [31:0] data,
  output logic        tx,
  output logic        busy,
  output logic        done
);

  localparam int CW = $clog2(CLKS_PER_BIT);
  localparam logic [CW-1:0] CNT_MAX = CW'(CLKS_PER_BIT - 1);
  localparam logic [1:0] LAST_BYTE = 2'(NBYTES - 1);

  typedef enum logic [1:0] {
    S_IDLE,
    S_START,
    S_DATA,
    S_STOP
  } state_t;

  state_t        state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [2:0]    bit_q, bit_d;
  logic [1:0]    byte_q, byte_d;
  logic [7:0]    shift_q, shift_d;
  logic [31:0]   word_q, word_d;
  logic          tx_q, tx_d;
  logic          busy_q, busy_d;
  logic          done_q, done_d;

  logic          bit_end;
  logic [1:0]    next_byte;

  assign bit_end   = (cnt_q == CNT_MAX);
  assign next_byte = byte_q + 2'd1;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    bit_d   = bit_q;
    byte_d  = byte_q;
    shift_d = shift_q;
    word_d  = word_q;
    tx_d    = tx_q;
    busy_d  = busy_q;
    done_d  = 1'b0;

    unique case (state_q)
      S_IDLE: begin
        tx_d   = 1'b1;
        busy_d = 1'b0;
        cnt_d  = '0;
        if (send) begin
          word_d  = data;
          byte_d  = 2'd0;
          bit_d   = 3'd0;
          shift_d = data[7:0];
          busy_d  = 1'b1;
          tx_d    = 1'b0;
          state_d = S_START;
        end
      end

      S_START: begin
        if (bit_end) begin
          cnt_d   = '0;
          bit_d   = 3'd0;
          tx_d    = shift_q[0];
          state_d = S_DATA;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end

      S_DATA: begin
        if (bit_end) begin
          cnt_d   = '0;
          shift_d = {1'b0, shift_q[7:1]};
          if (bit_q == 3'd7) begin
            tx_d    = 1'b1;
            state_d = S_STOP;
          end else begin
            bit_d = bit_q + 3'd1;
            // next bit is the one the shift above brings to bit 0
            tx_d  = shift_q[1];
          end
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end

      S_STOP: begin
        if (bit_end) begin
          cnt_d = '0;
          if (byte_q < LAST_BYTE) begin
            // chain straight into the next start bit, no idle gap
            byte_d  = next_byte;
            bit_d   = 3'd0;
            shift_d = word_q[{next_byte, 3'b000} +: 8];
            tx_d    = 1'b0;
            state_d = S_START;
          end else begin
            tx_d    = 1'b1;
            busy_d  = 1'b0;
            done_d  = 1'b1;
            state_d = S_IDLE;
          end
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end

      default: begin
        state_d = S_IDLE;
        tx_d    = 1'b1;
        busy_d  = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      bit_q   <= '0;
      byte_q  <= '0;
      shift_q <= '0;
      word_q  <= '0;
      tx_q    <= 1'b1;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      bit_q   <= bit_d;
      byte_q  <= byte_d;
      shift_q <= shift_d;
      word_q  <= word_d;
      tx_q    <= tx_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
    end
  end

  assign tx   = tx_q;
  assign busy = busy_q;
  assign done = done_q;

endmodule

// File: tb/tb_uart_word_tx.sv
// tb_uart_word_tx: scoreboard bench for uart_word_tx (4 clk/bit).
// A line monitor decodes frames and pops expected bytes from a queue.
module tb_uart_word_tx;

  logic        clock;
  logic        reset;
  logic        send;
  logic [31:0] data;
  logic        tx;
  logic        busy;
  logic        done;

  logic        send1;
  logic [31:0] data1;
  logic        tx1;
  logic        busy1;
  logic        done1;

  int vectors;
  int miscompares;

  logic [7:0] exp_q[$];
  logic [7:0] exp1_q[$];

  uart_word_tx #(.CLKS_PER_BIT(4), .NBYTES(4)) dut (
    .clock(clock), .reset(reset), .send(send), .data(data),
    .tx(tx), .busy(busy), .done(done)
  );

  uart_word_tx #(.CLKS_PER_BIT(4), .NBYTES(1)) dut1 (
    .clock(clock), .reset(reset), .send(send1), .data(data1),
    .tx(tx1), .busy(busy1), .done(done1)
  );

  always #5 clock = ~clock;

  // line monitor: mon_cnt 0 is the first cycle of a start bit,
  // samples at the middle of each 4-cycle bit
  logic       mon_active;
  int         mon_cnt;
  logic [7:0] mon_byte;
  logic [7:0] mon_exp;

  initial begin
    mon_active = 1'b0;
    mon_cnt    = 0;
    mon_byte   = '0;
    forever begin
      @(negedge clock);
      if (reset) begin
        mon_active = 1'b0;
      end else begin
        if (!mon_active) begin
          if (tx === 1'b0) begin
            mon_active = 1'b1;
            mon_cnt    = 0;
          end
        end else begin
          mon_cnt++;
        end
        if (mon_active && (mon_cnt % 4 == 2)) begin
          if (mon_cnt / 4 == 0) begin
            vectors++;
            if (tx !== 1'b0) begin
              miscompares++;
              $display("FAIL start_bit: got %b want 0 at %0t", tx, $time);
            end
          end else if (mon_cnt / 4 <= 8) begin
            mon_byte[mon_cnt/4-1] = tx;
          end else begin
            vectors++;
            if (tx !== 1'b1) begin
              miscompares++;
              $display("FAIL stop_bit: got %b want 1 at %0t", tx, $time);
            end
            vectors++;
            if (exp_q.size() == 0) begin
              miscompares++;
              $display("FAIL frame: got %h want none (unexpected frame)",
                       mon_byte);
            end else begin
              mon_exp = exp_q.pop_front();
              if (mon_byte !== mon_exp) begin
                miscompares++;
                $display("FAIL frame_byte: got %h want %h", mon_byte, mon_exp);
              end
            end
            mon_active = 1'b0;
          end
        end
      end
    end
  end

  // drives a word from the current negedge and runs until busy drops;
  // returns at the negedge following the falling edge of busy
  task automatic drive_word(input logic [31:0] w, input int poke,
                            output int nbusy, output logic first_tx,
                            output logic end_done, output logic end_tx);
    logic [31:0] wv;
    wv = w;
    send = 1'b1;
    data = w;
    for (int k = 0; k < 4; k++) exp_q.push_back(wv[8*k +: 8]);
    nbusy    = 0;
    first_tx = 1'b1;
    for (int i = 0; i < 2000; i++) begin
      @(negedge clock);
      if (i == 0) first_tx = tx;
      if (!busy) break;
      nbusy++;
      if (nbusy == poke) begin
        send = 1'b1;
        data = 32'hDEADBEEF;
      end else begin
        send = 1'b0;
        data = ~w ^ 32'(nbusy);
      end
    end
    end_done = done;
    end_tx   = tx;
    send     = 1'b0;
  endtask

  task automatic test_reset;
    logic line_ok;
    line_ok = 1'b1;
    reset = 1'b1;
    send  = 1'b1;
    data  = 32'hFFFFFFFF;
    repeat (6) begin
      @(negedge clock);
      if (tx !== 1'b1 || busy !== 1'b0) line_ok = 1'b0;
    end
    vectors++;
    if (tx !== 1'b1) begin
      miscompares++;
      $display("FAIL reset_tx: got %b want 1", tx);
    end
    vectors++;
    if (busy !== 1'b0) begin
      miscompares++;
      $display("FAIL reset_busy: got %b want 0", busy);
    end
    vectors++;
    if (done !== 1'b0) begin
      miscompares++;
      $display("FAIL reset_done: got %b want 0", done);
    end
    vectors++;
    if (line_ok !== 1'b1) begin
      miscompares++;
      $display("FAIL reset_hold_send: got %b want 1 (line idle)", line_ok);
    end
    send = 1'b0;
    @(negedge clock);
    reset = 1'b0;
    repeat (3) @(negedge clock);
    vectors++;
    if (busy !== 1'b0 || tx !== 1'b1) begin
      miscompares++;
      $display("FAIL post_reset_idle: got busy=%b tx=%b want 0/1", busy, tx);
    end
  endtask

  task automatic test_single(input logic [31:0] w);
    int   nb;
    logic ftx, edone, etx;
    drive_word(w, 0, nb, ftx, edone, etx);
    vectors++;
    if (nb !== 160) begin
      miscompares++;
      $display("FAIL busy_len %h: got %0d want 160", w, nb);
    end
    vectors++;
    if (ftx !== 1'b0) begin
      miscompares++;
      $display("FAIL first_start %h: got %b want 0", w, ftx);
    end
    vectors++;
    if (edone !== 1'b1) begin
      miscompares++;
      $display("FAIL done_pulse %h: got %b want 1", w, edone);
    end
    @(negedge clock);
    vectors++;
    if (done !== 1'b0 || busy !== 1'b0) begin
      miscompares++;
      $display("FAIL done_one_cycle %h: got done=%b busy=%b want 0/0",
               w, done, busy);
    end
    vectors++;
    if (exp_q.size() != 0) begin
      miscompares++;
      $display("FAIL frames_left %h: got %0d want 0", w, exp_q.size());
    end
  endtask

  task automatic test_ignored;
    int   nb;
    logic ftx, edone, etx, idle_ok;
    drive_word(32'h0BADF00D, 20, nb, ftx, edone, etx);
    vectors++;
    if (nb !== 160 || edone !== 1'b1) begin
      miscompares++;
      $display("FAIL ignored_len: got %0d/%b want 160/1", nb, edone);
    end
    idle_ok = 1'b1;
    repeat (60) begin
      @(negedge clock);
      if (busy !== 1'b0 || tx !== 1'b1) idle_ok = 1'b0;
    end
    vectors++;
    if (idle_ok !== 1'b1) begin
      miscompares++;
      $display("FAIL ignored_no_second: got %b want 1 (idle)", idle_ok);
    end
    vectors++;
    if (exp_q.size() != 0) begin
      miscompares++;
      $display("FAIL ignored_frames_left: got %0d want 0", exp_q.size());
    end
  endtask

  task automatic test_back_to_back;
    int   nb;
    logic ftx, edone, etx;
    drive_word(32'hA5A50F0F, 0, nb, ftx, edone, etx);
    vectors++;
    if (edone !== 1'b1 || etx !== 1'b1) begin
      miscompares++;
      $display("FAIL b2b_gap_cycle: got done=%b tx=%b want 1/1", edone, etx);
    end
    drive_word(32'hCAFEBABE, 0, nb, ftx, edone, etx);
    vectors++;
    if (ftx !== 1'b0) begin
      miscompares++;
      $display("FAIL b2b_start: got %b want 0", ftx);
    end
    vectors++;
    if (nb !== 160 || edone !== 1'b1) begin
      miscompares++;
      $display("FAIL b2b_len: got %0d/%b want 160/1", nb, edone);
    end
    @(negedge clock);
    vectors++;
    if (exp_q.size() != 0) begin
      miscompares++;
      $display("FAIL b2b_frames_left: got %0d want 0", exp_q.size());
    end
  endtask

  task automatic test_mid_reset;
    logic [31:0] w;
    logic        no_done;
    w = 32'h11223344;
    send = 1'b1;
    data = w;
    for (int k = 0; k < 4; k++) exp_q.push_back(w[8*k +: 8]);
    @(negedge clock);
    send = 1'b0;
    repeat (90) @(negedge clock);
    vectors++;
    if (busy !== 1'b1) begin
      miscompares++;
      $display("FAIL midrst_busy_before: got %b want 1", busy);
    end
    #1 reset = 1'b1;
    #1;
    vectors++;
    if (tx !== 1'b1 || busy !== 1'b0) begin
      miscompares++;
      $display("FAIL midrst_async: got tx=%b busy=%b want 1/0", tx, busy);
    end
    vectors++;
    if (exp_q.size() != 2) begin
      miscompares++;
      $display("FAIL midrst_frames_sent: got %0d left want 2", exp_q.size());
    end
    exp_q.delete();
    no_done = 1'b1;
    repeat (3) begin
      @(negedge clock);
      if (done !== 1'b0) no_done = 1'b0;
    end
    reset = 1'b0;
    repeat (10) begin
      @(negedge clock);
      if (done !== 1'b0 || tx !== 1'b1) no_done = 1'b0;
    end
    vectors++;
    if (no_done !== 1'b1) begin
      miscompares++;
      $display("FAIL midrst_no_done: got %b want 1", no_done);
    end
    test_single(32'h01020304);
  endtask

  task automatic test_nbytes1;
    int         nb;
    logic [7:0] b;
    logic [7:0] e;
    logic       st, sp, dn;
    send1 = 1'b1;
    data1 = 32'h123456AB;
    exp1_q.push_back(8'hAB);
    nb = 0;
    b  = '0;
    st = 1'b1;
    sp = 1'b0;
    for (int i = 0; i < 200; i++) begin
      @(negedge clock);
      if (i == 0) send1 = 1'b0;
      if (!busy1) break;
      nb++;
      if (i % 4 == 2) begin
        if (i / 4 == 0) st = tx1;
        else if (i / 4 <= 8) b[i/4-1] = tx1;
        else sp = tx1;
      end
    end
    dn = done1;
    vectors++;
    if (nb !== 40 || dn !== 1'b1) begin
      miscompares++;
      $display("FAIL nb1_busy: got %0d/%b want 40/1", nb, dn);
    end
    vectors++;
    if (st !== 1'b0 || sp !== 1'b1) begin
      miscompares++;
      $display("FAIL nb1_framing: got start=%b stop=%b want 0/1", st, sp);
    end
    e = exp1_q.pop_front();
    vectors++;
    if (b !== e) begin
      miscompares++;
      $display("FAIL nb1_byte: got %h want %h", b, e);
    end
    @(negedge clock);
    vectors++;
    if (done1 !== 1'b0 || tx1 !== 1'b1) begin
      miscompares++;
      $display("FAIL nb1_idle: got done=%b tx=%b want 0/1", done1, tx1);
    end
  endtask

  initial begin
    clock       = 1'b0;
    reset       = 1'b1;
    send        = 1'b0;
    data        = '0;
    send1       = 1'b0;
    data1       = '0;
    vectors     = 0;
    miscompares = 0;
    test_reset();
    test_single(32'h12345678);
    test_single(32'h00000000);
    test_single(32'hFFFFFFFF);
    test_nbytes1();
    test_ignored();
    test_back_to_back();
    test_mid_reset();
    repeat (5) @(negedge clock);
    $display("== %0d vectors applied, %0d miscompares ==",
             vectors, miscompares);
    $finish;
  end

endmodule
